// File: rtl/asconp_sched.sv
// Ascon-p scheduler: round-robin arbitration between two requesters, state register and round sequencing.
// Optional abort input is enabled with `define ASCONP_SCHED_ABORT_EN.

module asconp #(
   parameter int unsigned UROL = 1
) (
   input  logic [3:0]   round_cnt,
   input  logic [319:0] state_in,
   output logic [319:0] state_out
);

   function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Round constant for round index 12 - round_cnt + i of p12.
   function automatic logic [7:0] rc_of(input logic [3:0] cnt, input int unsigned i);
      logic [3:0] r;
      r = 4'(4'd12 - cnt + 4'(i));
      return {4'hf - r, r};
   endfunction

   function automatic logic [319:0] round(input logic [319:0] s, input logic [7:0] rc);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      x0 = s[319:256];
      x1 = s[255:192];
      x2 = s[191:128] ^ {56'd0, rc};
      x3 = s[127:64];
      x4 = s[63:0];
      // Bitsliced 5-bit S-box
      x0 ^= x4;
      x4 ^= x3;
      x2 ^= x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 ^= t1;
      x1 ^= t2;
      x2 ^= t3;
      x3 ^= t4;
      x4 ^= t0;
      x1 ^= x0;
      x0 ^= x4;
      x3 ^= x2;
      x2 = ~x2;
      // Linear diffusion layer
      x0 ^= ror(x0, 19) ^ ror(x0, 28);
      x1 ^= ror(x1, 61) ^ ror(x1, 39);
      x2 ^= ror(x2, 1)  ^ ror(x2, 6);
      x3 ^= ror(x3, 10) ^ ror(x3, 17);
      x4 ^= ror(x4, 7)  ^ ror(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   logic [319:0] stage [UROL+1];

   assign stage[0] = state_in;

   for (genvar i = 0; i < int'(UROL); i++) begin : g_round
      assign stage[i+1] = round(stage[i], rc_of(round_cnt, i));
   end

   assign state_out = stage[UROL];

endmodule

module asconp_sched (
   input  logic         clk,
   input  logic         rst_n,
`ifdef ASCONP_SCHED_ABORT_EN
   input  logic         abort,
`endif
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [3:0]   req0_rounds,
   input  logic [319:0] req0_state,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [3:0]   req1_rounds,
   input  logic [319:0] req1_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [319:0] out_state,
   output logic         out_tag,
   output logic         out_err
);

   localparam int unsigned UROL       = 1;
   localparam int unsigned MAX_ROUNDS = 12;

   // Round counts accepted for the configured unroll factor.
   function automatic logic [15:0] legal_mask();
      logic [15:0] m;
      m = '0;
      for (int unsigned r = 1; r <= MAX_ROUNDS; r++) begin
         if (r % UROL == 0) m[r] = 1'b1;
      end
      return m;
   endfunction

   localparam logic [15:0] LEGAL = legal_mask();

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       st, st_nxt;
   logic [3:0]   rcnt, rcnt_nxt;
   logic [319:0] sreg, sreg_nxt;
   logic         tag, tag_nxt;
   logic         err, err_nxt;
   logic         last_gnt, last_gnt_nxt;
   logic         valid_q;
   logic [319:0] perm_out;

   logic         gnt_c;
   logic         acc_c;
   logic [3:0]   rounds_c;

   asconp #(.UROL(UROL)) u_perm (
      .round_cnt (rcnt),
      .state_in  (sreg),
      .state_out (perm_out)
   );

   // State register and job bookkeeping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st       <= IDLE;
         rcnt     <= 4'd0;
         sreg     <= '0;
         tag      <= 1'b0;
         err      <= 1'b0;
         last_gnt <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         st       <= st_nxt;
         rcnt     <= rcnt_nxt;
         sreg     <= sreg_nxt;
         tag      <= tag_nxt;
         err      <= err_nxt;
         last_gnt <= last_gnt_nxt;
         valid_q  <= (st_nxt == DONE);
      end
   end

   // Arbitration, accept and round sequencing
   always_comb begin
      st_nxt       = st;
      rcnt_nxt     = rcnt;
      sreg_nxt     = sreg;
      tag_nxt      = tag;
      err_nxt      = err;
      last_gnt_nxt = last_gnt;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      acc_c        = 1'b0;

      // Contention goes to the requester not served last
      gnt_c    = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
      rounds_c = gnt_c ? req1_rounds : req0_rounds;

      case (st)
         IDLE: begin
            req0_ready = req0_valid & ~gnt_c;
            req1_ready = req1_valid & gnt_c;
            acc_c      = req0_valid | req1_valid;
            if (acc_c) begin
               sreg_nxt     = gnt_c ? req1_state : req0_state;
               tag_nxt      = gnt_c;
               last_gnt_nxt = gnt_c;
               if (LEGAL[rounds_c]) begin
                  err_nxt  = 1'b0;
                  rcnt_nxt = rounds_c;
                  st_nxt   = RUN;
               end else begin
                  err_nxt = 1'b1;
                  st_nxt  = DONE;
               end
            end
         end
         RUN: begin
            sreg_nxt = perm_out;
            rcnt_nxt = rcnt - 4'(UROL);
            if (rcnt == 4'(UROL)) st_nxt = DONE;
`ifdef ASCONP_SCHED_ABORT_EN
            if (abort) begin
               st_nxt   = IDLE;
               rcnt_nxt = 4'd0;
            end
`endif
         end
         DONE: begin
            if (out_ready) begin
               st_nxt  = IDLE;
               err_nxt = 1'b0;
            end
         end
         default: st_nxt = IDLE;
      endcase
   end

   assign out_valid = valid_q;
   assign out_state = sreg;
   assign out_tag   = tag;
   assign out_err   = err;

endmodule

// File: tb/tb_asconp_sched.sv
// Randomized bench for asconp_sched against a table-driven Ascon-p reference model.
module tb_asconp_sched;

   localparam int UROL = 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready;
   logic [3:0]   req0_rounds;
   logic [319:0] req0_state;
   logic         req1_valid, req1_ready;
   logic [3:0]   req1_rounds;
   logic [319:0] req1_state;
   logic         out_valid, out_ready;
   logic [319:0] out_state;
   logic         out_tag, out_err;
`ifdef ASCONP_SCHED_ABORT_EN
   logic         abort;
`endif

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   localparam logic [7:0] RC [12] = '{
      8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
      8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

   asconp_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef ASCONP_SCHED_ABORT_EN
      .abort       (abort),
`endif
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_rounds (req0_rounds),
      .req0_state  (req0_state),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_rounds (req1_rounds),
      .req1_state  (req1_state),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_state   (out_state),
      .out_tag     (out_tag),
      .out_err     (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rot(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Last `rounds` rounds of p12, S-box applied per bit column via lookup table
   function automatic logic [319:0] ref_perm(input logic [319:0] s, input int rounds);
      logic [63:0] x [5];
      logic [4:0]  col;
      logic [4:0]  sb;
      for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
      for (int r = 12 - rounds; r < 12; r++) begin
         x[2] ^= {56'd0, RC[r]};
         for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            sb  = SBOX[col];
            for (int k = 0; k < 5; k++) x[k][b] = sb[4-k];
         end
         x[0] ^= rot(x[0], 19) ^ rot(x[0], 28);
         x[1] ^= rot(x[1], 61) ^ rot(x[1], 39);
         x[2] ^= rot(x[2], 1)  ^ rot(x[2], 6);
         x[3] ^= rot(x[3], 10) ^ rot(x[3], 17);
         x[4] ^= rot(x[4], 7)  ^ rot(x[4], 41);
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   function automatic bit is_legal(input int rounds);
      return rounds >= 1 && rounds <= 12 && (rounds % UROL) == 0;
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] v;
      for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic who, input logic v, input logic [3:0] rounds, input logic [319:0] s);
      if (who) begin
         req1_valid = v; req1_rounds = rounds; req1_state = s;
      end else begin
         req0_valid = v; req0_rounds = rounds; req0_state = s;
      end
   endtask

   // One job end to end; checks latency, round counter walk and result
   task automatic run_job(input logic who, input int rounds, input logic [319:0] s, input int hold);
      int           n;
      int           lat;
      int           bad;
      int           exp_r;
      bit           legal;
      logic [319:0] exp_s;
      legal = is_legal(rounds);
      exp_s = legal ? ref_perm(s, rounds) : s;
      drive(who, 1'b1, 4'(rounds), s);
      #1;
      n = 0;
      while (!(who ? req1_ready : req0_ready) && n < 50) begin
         step();
         #1;
         n++;
      end
      check("accept_timeout", 320'(n < 50), 320'(1));
      step();
      drive(who, 1'b0, 4'(rounds), s);
      lat   = 1;
      bad   = 0;
      exp_r = rounds;
      while (!out_valid && lat < 40) begin
         if (legal && dut.rcnt !== 4'(exp_r)) bad++;
         exp_r -= UROL;
         step();
         lat++;
      end
      check("latency", 320'(lat), 320'(legal ? 1 + rounds / UROL : 1));
      if (legal) check("rcnt_seq", 320'(bad), 320'(0));
      check("out_state", out_state, exp_s);
      check("out_tag", 320'(out_tag), 320'(who));
      check("out_err", 320'(out_err), 320'(!legal));
      for (int i = 0; i < hold; i++) begin
         step();
         check("hold_state", out_state, exp_s);
         check("hold_valid", 320'(out_valid), 320'(1));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("release_valid", 320'(out_valid), 320'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin : main
      int           n;
      int           both_hi;
      int           bad;
      int           exp_g;
      logic [319:0] s;
      logic [319:0] exp_s;
      int           grants [$];

      rst_n      = 1'b0;
      out_ready  = 1'b0;
      req0_valid = 1'b0; req0_rounds = '0; req0_state = '0;
      req1_valid = 1'b0; req1_rounds = '0; req1_state = '0;
`ifdef ASCONP_SCHED_ABORT_EN
      abort      = 1'b0;
`endif
      do_reset();

      check("rst_valid", 320'(out_valid), 320'(0));
      check("rst_state", out_state, 320'(0));
      check("rst_tag", 320'(out_tag), 320'(0));
      check("rst_err", 320'(out_err), 320'(0));
      check("rst_ready", 320'({req0_ready, req1_ready}), 320'(0));

      // p12 of the all-zero state
      run_job(1'b0, 12, 320'(0), 0);
      // Partial permutations on random states
      run_job(1'b1, 6, rand320(), 1);
      run_job(1'b1, 8, rand320(), 0);
      // Rejected round counts return the input unchanged
      run_job(1'b0, 0, rand320(), 0);
      run_job(1'b0, 13, rand320(), 2);

      for (int j = 0; j < 24; j++)
         run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), rand320(), int'($urandom_range(0, 3)));

      // Back-pressure in DONE with both requesters waiting
      s     = rand320();
      exp_s = ref_perm(s, 4);
      drive(1'b1, 1'b1, 4'd4, s);
      step();
      drive(1'b1, 1'b0, 4'd4, s);
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      check("bp_valid", 320'(out_valid), 320'(1));
      drive(1'b0, 1'b1, 4'(UROL), rand320());
      drive(1'b1, 1'b1, 4'(UROL), rand320());
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_state !== exp_s || out_tag !== 1'b1 || out_valid !== 1'b1) bad++;
         if (req0_ready || req1_ready) bad++;
         step();
      end
      check("bp_stable", 320'(bad), 320'(0));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_rel_valid", 320'(out_valid), 320'(0));
      check("bp_next_ready", 320'({req0_ready, req1_ready}), 320'(2'b10));
      drive(1'b0, 1'b0, 4'(UROL), '0);
      drive(1'b1, 1'b0, 4'(UROL), '0);

      // Continuous contention from reset alternates starting with requester 0
      do_reset();
      out_ready = 1'b1;
      drive(1'b0, 1'b1, 4'(UROL), rand320());
      drive(1'b1, 1'b1, 4'(UROL), rand320());
      #1;
      both_hi = 0;
      for (int i = 0; i < 40; i++) begin
         if (req0_ready && req1_ready) both_hi++;
         if (req0_ready) grants.push_back(0);
         if (req1_ready) grants.push_back(1);
         step();
         #1;
      end
      check("rr_both_ready", 320'(both_hi), 320'(0));
      check("rr_count", 320'(grants.size() >= 8), 320'(1));
      bad   = 0;
      exp_g = 0;
      foreach (grants[i]) begin
         if (grants[i] != exp_g) bad++;
         exp_g = 1 - exp_g;
      end
      check("rr_order", 320'(bad), 320'(0));
      drive(1'b0, 1'b0, 4'(UROL), '0);
      drive(1'b1, 1'b0, 4'(UROL), '0);
      step();
      step();
      step();
      out_ready = 1'b0;

      // Reset while the round counter reads 5
      drive(1'b0, 1'b1, 4'd12, rand320());
      n = 0;
      while (dut.rcnt !== 4'd5 && n < 50) begin
         step();
         drive(1'b0, 1'b0, 4'd12, '0);
         n++;
      end
      check("mid_rcnt_reached", 320'(n < 50), 320'(1));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mid_rst_valid", 320'(out_valid), 320'(0));
      drive(1'b0, 1'b1, 4'(UROL), rand320());
      drive(1'b1, 1'b1, 4'(UROL), rand320());
      #1;
      check("mid_rst_grant", 320'({req0_ready, req1_ready}), 320'(2'b10));
      drive(1'b0, 1'b0, 4'(UROL), '0);
      drive(1'b1, 1'b0, 4'(UROL), '0);
      step();
      for (int i = 0; i < 3; i++) begin
         check("mid_rst_quiet", 320'(out_valid), 320'(0));
         step();
      end

`ifdef ASCONP_SCHED_ABORT_EN
      // Abort on the final round cycle wins over completion
      drive(1'b1, 1'b1, 4'd12, rand320());
      step();
      drive(1'b1, 1'b0, 4'd12, '0);
      n = 0;
      while (dut.rcnt !== 4'(UROL) && n < 50) begin
         step();
         n++;
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid) bad++;
         step();
      end
      check("abort_no_out", 320'(bad), 320'(0));
      drive(1'b0, 1'b1, 4'(UROL), rand320());
      #1;
      check("abort_idle", 320'(req0_ready), 320'(1));
      drive(1'b0, 1'b0, 4'(UROL), '0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
